// File: rtl/fetch_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_reg
//  Description : Two-entry fetch-packet skid register. in_ready is registered
//                so the upstream handshake has no combinational path from
//                out_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_reg #(
    parameter int                 INSTR_W   = 18,
    parameter int                 ADDR_W    = 10,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [ADDR_W-1:0]  in_alt,
    input  logic               in_taken,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [ADDR_W-1:0]  out_alt,
    output logic               out_taken,

    output logic [1:0]         occupancy
);

    localparam int c_PKT_W = INSTR_W + 2 * ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    // Declaration initialisers give power-up values equal to the reset values.
    state_t             r_state     = ST_EMPTY;
    logic               r_in_ready  = 1'b1;
    logic               r_out_valid = 1'b0;
    logic [c_PKT_W-1:0] r_main      = '0;
    logic [c_PKT_W-1:0] r_skid      = '0;

    logic               w_accept;
    logic               w_consume;
    logic [c_PKT_W-1:0] w_in_pkt;

    assign w_accept  = in_valid & r_in_ready;
    assign w_consume = r_out_valid & out_ready;
    assign w_in_pkt  = {in_instr, in_addr, in_alt, in_taken};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= w_in_pkt;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_consume && w_accept) begin
                        r_main <= w_in_pkt;
                    end else if (w_consume) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else if (w_accept) begin
                        r_skid      <= w_in_pkt;
                        r_state     <= ST_SKID;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only a consume can change state.
                    if (w_consume) begin
                        r_main      <= r_skid;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign occupancy = r_state;

    assign out_instr = r_out_valid ? r_main[c_PKT_W-1 -: INSTR_W]    : NOP_INSTR;
    assign out_addr  = r_out_valid ? r_main[2*ADDR_W   -: ADDR_W]    : '0;
    assign out_alt   = r_out_valid ? r_main[ADDR_W     -: ADDR_W]    : '0;
    assign out_taken = r_out_valid ? r_main[0]                       : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_skid_reg
//  Description : Directed self-checking bench for fetch_skid_reg.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_skid_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;

    // Default-parameter instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_instr = '0;
    logic [9:0]  in_addr  = '0;
    logic [9:0]  in_alt   = '0;
    logic        in_taken = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] out_instr;
    logic [9:0]  out_addr;
    logic [9:0]  out_alt;
    logic        out_taken;
    logic [1:0]  occupancy;

    // Wide-parameter instance
    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [31:0] in_instr2 = '0;
    logic [15:0] in_addr2  = '0;
    logic [15:0] in_alt2   = '0;
    logic        in_taken2 = 1'b0;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic [31:0] out_instr2;
    logic [15:0] out_addr2;
    logic [15:0] out_alt2;
    logic        out_taken2;
    logic [1:0]  occupancy2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_skid_reg u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_addr(in_addr), .in_alt(in_alt), .in_taken(in_taken),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_alt(out_alt), .out_taken(out_taken),
        .occupancy(occupancy)
    );

    fetch_skid_reg #(
        .INSTR_W(32), .ADDR_W(16), .NOP_INSTR(32'h0000_0013)
    ) u_dut_wide (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_instr(in_instr2), .in_addr(in_addr2), .in_alt(in_alt2), .in_taken(in_taken2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_instr(out_instr2), .out_addr(out_addr2), .out_alt(out_alt2), .out_taken(out_taken2),
        .occupancy(occupancy2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [17:0] instr, input logic [9:0] addr,
                         input logic [9:0] alt, input logic taken);
        in_valid = 1'b1;
        in_instr = instr;
        in_addr  = addr;
        in_alt   = alt;
        in_taken = taken;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'd0);
        check({tag, ".ready"}, 64'(in_ready),  64'd1);
        check({tag, ".occ"},   64'(occupancy), 64'd0);
        check({tag, ".instr"}, 64'(out_instr), 64'd0);
        check({tag, ".addr"},  64'(out_addr),  64'd0);
        check({tag, ".alt"},   64'(out_alt),   64'd0);
        check({tag, ".taken"}, 64'(out_taken), 64'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");
        check("reset.wide_nop", 64'(out_instr2), 64'h13);

        // Pass-through
        out_ready = 1'b1;
        offer(18'h3_1234, 10'h005, 10'h010, 1'b1);
        tick();
        check("pass.valid", 64'(out_valid), 64'd1);
        check("pass.instr", 64'(out_instr), 64'h3_1234);
        check("pass.addr",  64'(out_addr),  64'h005);
        check("pass.alt",   64'(out_alt),   64'h010);
        check("pass.taken", 64'(out_taken), 64'd1);
        for (int i = 0; i < 4; i++) begin
            offer(18'(18'h100 + i), 10'(10'h040 + i), 10'(10'h080 + i), 1'(i));
            tick();
            check("stream.addr",  64'(out_addr),  64'(10'h040 + i));
            check("stream.instr", 64'(out_instr), 64'(18'h100 + i));
            check("stream.occ",   64'(occupancy), 64'd1);
            check("stream.ready", 64'(in_ready),  64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("drain.valid", 64'(out_valid), 64'd0);

        // Skid fill
        out_ready = 1'b0;
        offer(18'h0_000A, 10'h001, 10'h0, 1'b0);
        tick();
        check("skid.occA",   64'(occupancy), 64'd1);
        check("skid.rdyA",   64'(in_ready),  64'd1);
        offer(18'h0_000B, 10'h002, 10'h0, 1'b0);
        tick();
        check("skid.occB",   64'(occupancy), 64'd2);
        check("skid.rdyB",   64'(in_ready),  64'd0);
        check("skid.headB",  64'(out_addr),  64'h001);
        offer(18'h0_000C, 10'h003, 10'h0, 1'b0);
        tick();
        check("skid.occC",   64'(occupancy), 64'd2);
        check("skid.headC",  64'(out_addr),  64'h001);
        out_ready = 1'b1;
        tick();
        check("skid.outB",   64'(out_addr),  64'h002);
        check("skid.occ1",   64'(occupancy), 64'd1);
        check("skid.rdy1",   64'(in_ready),  64'd1);
        tick();
        check("skid.outC",   64'(out_addr),  64'h003);
        check("skid.instrC", 64'(out_instr), 64'h0_000C);
        in_valid = 1'b0;
        tick();
        check("skid.empty",  64'(out_valid), 64'd0);

        // Simultaneous accept and consume
        out_ready = 1'b0;
        offer(18'h0_0011, 10'h011, 10'h0, 1'b0);
        tick();
        out_ready = 1'b1;
        offer(18'h0_0012, 10'h012, 10'h0, 1'b0);
        tick();
        check("simul.addr", 64'(out_addr),  64'h012);
        check("simul.occ",  64'(occupancy), 64'd1);
        in_valid = 1'b0;
        tick();
        check("simul.empty", 64'(occupancy), 64'd0);

        // Flush in SKID with a same-cycle offer
        out_ready = 1'b0;
        offer(18'h0_0021, 10'h021, 10'h0, 1'b0);
        tick();
        offer(18'h0_0022, 10'h022, 10'h0, 1'b0);
        tick();
        check("flush.pre_occ", 64'(occupancy), 64'd2);
        flush = 1'b1;
        offer(18'h0_0023, 10'h023, 10'h0, 1'b1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_idle("flush");
        out_ready = 1'b1;
        tick();
        check("flush.nodeliver", 64'(out_valid), 64'd0);

        // Reset mid-operation with flush also high
        out_ready = 1'b0;
        offer(18'h0_0031, 10'h031, 10'h0, 1'b1);
        tick();
        offer(18'h0_0032, 10'h032, 10'h0, 1'b1);
        tick();
        check("rstmid.pre_occ", 64'(occupancy), 64'd2);
        rst = 1'b1;
        flush = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        check_idle("rstmid");

        // Wide-parameter instance
        check("wide.idle_nop", 64'(out_instr2), 64'h13);
        out_ready2 = 1'b0;
        in_valid2  = 1'b1;
        in_instr2  = 32'hDEAD_BEEF;
        in_addr2   = 16'hFFFF;
        in_alt2    = 16'h8001;
        in_taken2  = 1'b1;
        tick();
        in_valid2 = 1'b0;
        check("wide.valid", 64'(out_valid2), 64'd1);
        check("wide.instr", 64'(out_instr2), 64'hDEAD_BEEF);
        check("wide.addr",  64'(out_addr2),  64'hFFFF);
        check("wide.alt",   64'(out_alt2),   64'h8001);
        out_ready2 = 1'b1;
        tick();
        check("wide.drain_nop", 64'(out_instr2), 64'h13);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_skid_reg.md
FETCH_SKID_REG -- requirements
Module: fetch_skid_reg

Interface
REQ-001 SHALL have parameter INSTR_W, default 18: instruction width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10: PC and alternate-address width in bits.
REQ-003 SHALL have parameter NOP_INSTR, INSTR_W bits, default 0: instruction driven on out_instr while out_valid=0.
REQ-004 SHALL have port clk  input  1: rising-edge clock.
REQ-005 SHALL have port rst  input  1: reset rst, synchronous, active-high.
REQ-006 SHALL have port flush  input  1: discards all held entries.
REQ-007 SHALL have port in_valid  input  1: upstream offers a fetch packet.
REQ-008 SHALL have port in_ready  output  1: stage can accept a packet this cycle.
REQ-009 SHALL have ports in_instr  input  INSTR_W, in_addr  input  ADDR_W, in_alt  input  ADDR_W, in_taken  input  1: instruction, its PC, branch alternate address, predicted-taken flag.
REQ-010 SHALL have port out_valid  output  1: a held packet is presented downstream.
REQ-011 SHALL have port out_ready  input  1: downstream consumes the presented packet.
REQ-012 SHALL have ports out_instr  output  INSTR_W, out_addr  output  ADDR_W, out_alt  output  ADDR_W, out_taken  output  1: presented packet fields.
REQ-013 SHALL have port occupancy  output  2: number of held entries, 0..2.

Function
REQ-014 SHALL hold up to two packets: a main entry (presented) and a skid entry, with states EMPTY (0), ONE (1), SKID (2).
REQ-015 SHALL define accept = in_valid & in_ready, and consume = out_valid & out_ready.
REQ-016 SHALL drive in_ready from a register: in_ready=1 in EMPTY and ONE, 0 in SKID, with no combinational path from out_ready.
REQ-017 SHALL drive out_valid=1 in ONE and SKID, and 0 in EMPTY.
REQ-018 In EMPTY, on accept SHALL load main from the inputs and go to ONE; otherwise SHALL stay in EMPTY.
REQ-019 In ONE, SHALL make these transitions:
- consume without accept: go to EMPTY.
- consume with accept: load main from the inputs and stay in ONE.
- accept without consume: load skid from the inputs and go to SKID.
- neither: hold.
REQ-020 In SKID, on consume SHALL move skid into main and go to ONE; otherwise SHALL hold both entries unchanged.
REQ-021 SHALL give a latency of 1 cycle from accept in EMPTY to out_valid=1 with that packet.
REQ-022 SHALL sustain one packet per cycle when out_ready is held at 1.
REQ-023 SHALL preserve packet order and never drop or duplicate a packet.
REQ-024 While out_valid=0, SHALL drive out_instr=NOP_INSTR, out_addr=0, out_alt=0 and out_taken=0.
REQ-025 While out_valid=1, SHALL keep all out_* fields stable until consume.
REQ-026 On flush=1, SHALL go to EMPTY at the next edge and discard main, skid and any same-cycle accept.
REQ-027 SHALL hold in_ready=1 in the cycle after a flush.
REQ-028 SHALL give flush priority over accept and consume.
REQ-029 SHALL give rst priority over flush.
REQ-030 SHALL make occupancy equal the state encoding in every cycle.
REQ-031 SHALL pass all payload widths through unchanged, with no truncation or extension.

Reset
REQ-032 While rst=1 at a rising edge, SHALL enter EMPTY with main and skid payloads cleared to 0.
REQ-033 After reset SHALL read out_valid=0, in_ready=1, occupancy=0, out_instr=NOP_INSTR, and out_addr, out_alt, out_taken all 0.
REQ-034 SHALL apply reset in the same way when asserted mid-operation in any state, discarding held packets.
REQ-035 SHALL give power-up register values equal to the reset values.

Verification
REQ-036 Pass-through: out_ready=1, send instr 0x3_1234/addr 0x005/alt 0x010/taken 1 -> next cycle out_valid=1 with the same fields; a 4-packet stream emerges in order, one per cycle.
REQ-037 Skid fill: out_ready=0, offer A (addr 0x001) then B (addr 0x002) -> occupancy 1 then 2, in_ready=0 after B, C held off upstream; raise out_ready -> A, B, C delivered in order.
REQ-038 Simultaneous: in ONE holding A, accept B with out_ready=1 -> A consumed, main=B, occupancy stays 1.
REQ-039 Flush: in SKID with flush=1 and in_valid=1 -> next cycle occupancy=0, out_valid=0, out_instr=NOP_INSTR, in_ready=1, offered packet not delivered.
REQ-040 Reset mid-op: in SKID assert rst for 1 cycle with flush=1 -> all outputs at REQ-033 values.
REQ-041 Parameters: INSTR_W=32, ADDR_W=16, NOP_INSTR=0x0000_0013 -> idle out_instr=0x0000_0013, and addr 0xFFFF passes unchanged.
